// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multicycle CPU control unit:
// opcode/funct encodings, ALU operation codes, FSM states and instruction classes.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SUBI  = 6'h0E;
    localparam logic [5:0] OP_SUBIU = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;

    // ALU code bits: [5] arithmetic, [1] subtract, [0] unsigned
    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_ADDU  = 6'b100001;
    localparam logic [5:0] ALU_SUB   = 6'b100010;
    localparam logic [5:0] ALU_SUBU  = 6'b100011;
    localparam logic [5:0] ALU_LOAD  = 6'b001110;
    localparam logic [5:0] ALU_STORE = 6'b011110;
    localparam logic [5:0] ALU_BEQ   = 6'b000000;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE     = 3'd0,
        CLS_ARITH_IMM = 3'd1,
        CLS_LOAD      = 3'd2,
        CLS_STORE     = 3'd3,
        CLS_BRANCH    = 3'd4,
        CLS_NONE      = 3'd5
    } instr_class_e;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control-unit <-> datapath/memory signal bundle; master is the control FSM,
// slave is the datapath side that supplies the IR fields and status flags.
interface cpu_ctrl_fsm_if #(
    parameter int RETIRE_W = 32
);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                alu_zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                mem_addr_sel;
    logic                ir_write;
    logic                pc_write;
    logic                branch_taken;
    logic [5:0]          alu_control;
    logic                alu_src_imm;
    logic                reg_write;
    logic                reg_dst_rt;
    logic                mem_to_reg;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, branch_taken,
               alu_control, alu_src_imm, reg_write, reg_dst_rt, mem_to_reg,
               illegal, retired
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, branch_taken,
               alu_control, alu_src_imm, reg_write, reg_dst_rt, mem_to_reg,
               illegal, retired
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct -> ALU code, instruction
// class and illegal flag. Undecodable pairs yield code 0 and class NONE.
module alu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output logic [5:0]   alu_control,
    output instr_class_e instr_class,
    output logic         illegal
);

    // Opcode/funct lookup; anything not listed stays illegal
    always_comb begin
        alu_control = 6'b000000;
        instr_class = CLS_NONE;
        illegal     = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin alu_control = ALU_ADD;  instr_class = CLS_RTYPE; illegal = 1'b0; end
                    FN_ADDU: begin alu_control = ALU_ADDU; instr_class = CLS_RTYPE; illegal = 1'b0; end
                    FN_SUB:  begin alu_control = ALU_SUB;  instr_class = CLS_RTYPE; illegal = 1'b0; end
                    FN_SUBU: begin alu_control = ALU_SUBU; instr_class = CLS_RTYPE; illegal = 1'b0; end
                    default: begin alu_control = 6'b000000; instr_class = CLS_NONE; illegal = 1'b1; end
                endcase
            end
            OP_ADDI:  begin alu_control = ALU_ADD;   instr_class = CLS_ARITH_IMM; illegal = 1'b0; end
            OP_ADDIU: begin alu_control = ALU_ADDU;  instr_class = CLS_ARITH_IMM; illegal = 1'b0; end
            OP_SUBI:  begin alu_control = ALU_SUB;   instr_class = CLS_ARITH_IMM; illegal = 1'b0; end
            OP_SUBIU: begin alu_control = ALU_SUBU;  instr_class = CLS_ARITH_IMM; illegal = 1'b0; end
            OP_LW:    begin alu_control = ALU_LOAD;  instr_class = CLS_LOAD;      illegal = 1'b0; end
            OP_SW:    begin alu_control = ALU_STORE; instr_class = CLS_STORE;     illegal = 1'b0; end
            OP_BEQ:   begin alu_control = ALU_BEQ;   instr_class = CLS_BRANCH;    illegal = 1'b0; end
            default:  begin alu_control = 6'b000000; instr_class = CLS_NONE;      illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT sequencing,
// registered ALU code, sticky illegal flag and retired-instruction counter.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    cpu_ctrl_fsm_if.master bus
);

    state_e              state_r;
    state_e              next_state_s;
    logic [5:0]          alu_control_r;
    instr_class_e        class_r;
    logic                illegal_r;
    logic [RETIRE_W-1:0] retired_r;

    logic [5:0]          dec_alu_s;
    instr_class_e        dec_class_s;
    logic                dec_illegal_s;

    logic                retire_s;
    logic                mem_req_s;
    logic                mem_we_s;
    logic                mem_addr_sel_s;
    logic                ir_write_s;
    logic                pc_write_s;
    logic                branch_taken_s;
    logic                alu_src_imm_s;
    logic                reg_write_s;
    logic                reg_dst_rt_s;
    logic                mem_to_reg_s;

    alu_ctrl_decode u_decode (
        .opcode      (bus.opcode),
        .funct       (bus.funct),
        .alu_control (dec_alu_s),
        .instr_class (dec_class_s),
        .illegal     (dec_illegal_s)
    );

    // State register plus decode capture, sticky illegal and retire counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_FETCH;
            alu_control_r <= 6'b000000;
            class_r       <= CLS_NONE;
            illegal_r     <= 1'b0;
            retired_r     <= {RETIRE_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_DECODE) begin
                alu_control_r <= dec_alu_s;
                class_r       <= dec_class_s;
                illegal_r     <= illegal_r | dec_illegal_s;
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state and strobe decode; everything is held low while reset_n is low
    always_comb begin
        next_state_s   = state_r;
        retire_s       = 1'b0;
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        ir_write_s     = 1'b0;
        pc_write_s     = 1'b0;
        branch_taken_s = 1'b0;
        alu_src_imm_s  = 1'b0;
        reg_write_s    = 1'b0;
        reg_dst_rt_s   = 1'b0;
        mem_to_reg_s   = 1'b0;
        if (reset_n) begin
            case (state_r)
                ST_FETCH: begin
                    mem_req_s = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write_s   = 1'b1;
                        pc_write_s   = 1'b1;
                        next_state_s = ST_DECODE;
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal_s) begin
                        next_state_s = ST_HALT;
                    end else begin
                        next_state_s = ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (class_r)
                        CLS_RTYPE:     next_state_s = ST_WRITEBACK;
                        CLS_ARITH_IMM: begin alu_src_imm_s = 1'b1; next_state_s = ST_WRITEBACK; end
                        CLS_LOAD,
                        CLS_STORE:     begin alu_src_imm_s = 1'b1; next_state_s = ST_MEM; end
                        CLS_BRANCH: begin
                            branch_taken_s = bus.alu_zero;
                            retire_s       = 1'b1;
                            next_state_s   = ST_FETCH;
                        end
                        default:       next_state_s = ST_HALT;
                    endcase
                end
                ST_MEM: begin
                    mem_req_s      = 1'b1;
                    mem_addr_sel_s = 1'b1;
                    mem_we_s       = (class_r == CLS_STORE);
                    if (!bus.mem_ready) begin
                        next_state_s = ST_MEM;
                    end else if (class_r == CLS_STORE) begin
                        retire_s     = 1'b1;
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    reg_write_s  = 1'b1;
                    reg_dst_rt_s = (class_r != CLS_RTYPE);
                    mem_to_reg_s = (class_r == CLS_LOAD);
                    retire_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end
                ST_HALT:  next_state_s = ST_HALT;
                default:  next_state_s = ST_FETCH;
            endcase
        end else begin
            next_state_s = ST_FETCH;
        end
    end

    assign bus.mem_req      = mem_req_s;
    assign bus.mem_we       = mem_we_s;
    assign bus.mem_addr_sel = mem_addr_sel_s;
    assign bus.ir_write     = ir_write_s;
    assign bus.pc_write     = pc_write_s;
    assign bus.branch_taken = branch_taken_s;
    assign bus.alu_control  = alu_control_r;
    assign bus.alu_src_imm  = alu_src_imm_s;
    assign bus.reg_write    = reg_write_s;
    assign bus.reg_dst_rt   = reg_dst_rt_s;
    assign bus.mem_to_reg   = mem_to_reg_s;
    assign bus.illegal      = illegal_r;
    assign bus.retired      = retired_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-cycle expectations for each instruction
// class, memory wait states, illegal halt and reset abandonment.
module tb_cpu_ctrl_fsm;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   req_cnt = 0;
    int   wr_cnt = 0;
    int   overlap_cnt = 0;
    int   req_base = 0;
    int   wr_base = 0;

    cpu_ctrl_fsm_if #(.RETIRE_W(32)) bus ();

    cpu_ctrl_fsm #(.RETIRE_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Running counts of request cycles, write strobes and pc/branch overlaps
    always @(posedge clk) begin
        if (bus.mem_req) req_cnt <= req_cnt + 1;
        if (bus.reg_write) wr_cnt <= wr_cnt + 1;
        if (bus.pc_write && bus.branch_taken) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic zero);
        bus.mem_ready = rdy;
        bus.alu_zero  = zero;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] op, input logic [5:0] fn);
        reset_n       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.opcode    = op;
        bus.funct     = fn;
        tick();
        tick();
        reset_n  = 1'b1;
        req_base = req_cnt;
        wr_base  = wr_cnt;
    endtask

    logic [5:0] t_op  [8] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0E, 6'h0F};
    logic [5:0] t_fn  [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] t_alu [8] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                              6'b100000, 6'b100001, 6'b100010, 6'b100011};
    logic       t_rt  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        bus.opcode    = 6'h00;
        bus.funct     = 6'h20;
        bus.mem_ready = 1'b1;
        bus.alu_zero  = 1'b0;

        // reset state
        step(1'b1, 1'b0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_ir_write", 32'(bus.ir_write), 32'd0);
        tick();
        check("rst_alu_control", 32'(bus.alu_control), 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);

        // arithmetic R-type and immediate, zero-wait
        for (int i = 0; i < 8; i++) begin
            do_reset(t_op[i], t_fn[i]);
            step(1'b1, 1'b0);
            check($sformatf("ar%0d_fetch_req", i), 32'(bus.mem_req), 32'd1);
            check($sformatf("ar%0d_ir_pc", i), 32'({bus.ir_write, bus.pc_write}), 32'd3);
            tick();
            step(1'b0, 1'b0);
            check($sformatf("ar%0d_dec_req", i), 32'(bus.mem_req), 32'd0);
            tick();
            step(1'b0, 1'b0);
            check($sformatf("ar%0d_alu", i), 32'(bus.alu_control), 32'(t_alu[i]));
            check($sformatf("ar%0d_src_imm", i), 32'(bus.alu_src_imm), 32'(t_rt[i]));
            check($sformatf("ar%0d_ex_regwr", i), 32'(bus.reg_write), 32'd0);
            tick();
            step(1'b0, 1'b0);
            check($sformatf("ar%0d_regwr", i), 32'(bus.reg_write), 32'd1);
            check($sformatf("ar%0d_dst_rt", i), 32'(bus.reg_dst_rt), 32'(t_rt[i]));
            check($sformatf("ar%0d_mem2reg", i), 32'(bus.mem_to_reg), 32'd0);
            tick();
            step(1'b0, 1'b0);
            check($sformatf("ar%0d_next_fetch", i), 32'(bus.mem_req), 32'd1);
            check($sformatf("ar%0d_retired", i), bus.retired, 32'd1);
            tick();
        end

        // three back-to-back adds accumulate the retire count
        do_reset(6'h00, 6'h20);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0); tick();
            step(1'b0, 1'b0); tick();
            step(1'b0, 1'b0); tick();
            step(1'b0, 1'b0); tick();
        end
        step(1'b0, 1'b0);
        check("add3_retired", bus.retired, 32'd3);
        check("add3_regwr_count", 32'(wr_cnt - wr_base), 32'd3);
        tick();

        // lw with three wait cycles on each access
        do_reset(6'h23, 6'h00);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            check("lw_fetch_wait_irw", 32'(bus.ir_write), 32'd0);
            tick();
        end
        step(1'b1, 1'b0);
        check("lw_fetch_irw", 32'(bus.ir_write), 32'd1);
        tick();
        step(1'b0, 1'b0); tick();
        step(1'b0, 1'b0);
        check("lw_ex_alu", 32'(bus.alu_control), 32'b001110);
        check("lw_ex_src_imm", 32'(bus.alu_src_imm), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            check("lw_mem_alu", 32'(bus.alu_control), 32'b001110);
            check("lw_mem_sel_we", 32'({bus.mem_req, bus.mem_addr_sel, bus.mem_we}), 32'b110);
            tick();
        end
        step(1'b1, 1'b0);
        check("lw_mem_accept_req", 32'(bus.mem_req), 32'd1);
        tick();
        step(1'b0, 1'b0);
        check("lw_wb_regwr", 32'(bus.reg_write), 32'd1);
        check("lw_wb_mem2reg", 32'(bus.mem_to_reg), 32'd1);
        check("lw_wb_dst_rt", 32'(bus.reg_dst_rt), 32'd1);
        check("lw_wb_alu", 32'(bus.alu_control), 32'b001110);
        tick();
        check("lw_req_cycles", 32'(req_cnt - req_base), 32'd8);
        check("lw_retired", bus.retired, 32'd1);

        // sw zero-wait
        do_reset(6'h2B, 6'h00);
        step(1'b1, 1'b0); tick();
        step(1'b0, 1'b0); tick();
        step(1'b0, 1'b0);
        check("sw_ex_alu", 32'(bus.alu_control), 32'b011110);
        check("sw_ex_we", 32'({bus.mem_req, bus.mem_we}), 32'd0);
        tick();
        step(1'b1, 1'b0);
        check("sw_mem_req_sel_we", 32'({bus.mem_req, bus.mem_addr_sel, bus.mem_we}), 32'b111);
        check("sw_mem_regwr", 32'(bus.reg_write), 32'd0);
        tick();
        step(1'b0, 1'b0);
        check("sw_next_fetch", 32'({bus.mem_req, bus.mem_addr_sel, bus.mem_we}), 32'b100);
        check("sw_retired", bus.retired, 32'd1);
        tick();
        check("sw_no_regwr", 32'(wr_cnt - wr_base), 32'd0);

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            do_reset(6'h04, 6'h00);
            step(1'b1, 1'b0); tick();
            step(1'b0, 1'b0); tick();
            step(1'b0, z[0]);
            check($sformatf("beq%0d_taken", z), 32'(bus.branch_taken), 32'(z));
            check($sformatf("beq%0d_pc_write", z), 32'(bus.pc_write), 32'd0);
            check($sformatf("beq%0d_src_imm", z), 32'(bus.alu_src_imm), 32'd0);
            check($sformatf("beq%0d_alu", z), 32'(bus.alu_control), 32'd0);
            tick();
            step(1'b0, 1'b1);
            check($sformatf("beq%0d_fetch", z), 32'({bus.mem_req, bus.branch_taken}), 32'b10);
            check($sformatf("beq%0d_retired", z), bus.retired, 32'd1);
            tick();
        end

        // illegal opcode halts until reset
        do_reset(6'h3F, 6'h00);
        step(1'b1, 1'b0); tick();
        step(1'b0, 1'b0);
        check("ill_dec_flag", 32'(bus.illegal), 32'd0);
        tick();
        step(1'b1, 1'b0);
        check("ill_flag", 32'(bus.illegal), 32'd1);
        check("ill_halt_req", 32'(bus.mem_req), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0); tick();
        end
        check("ill_req_count", 32'(req_cnt - req_base), 32'd1);
        check("ill_retired", bus.retired, 32'd0);
        reset_n = 1'b0;
        step(1'b1, 1'b0);
        check("ill_rst_req", 32'(bus.mem_req), 32'd0);
        tick();
        check("ill_cleared", 32'(bus.illegal), 32'd0);
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        check("ill_restart_fetch", 32'({bus.mem_req, bus.mem_addr_sel}), 32'b10);
        tick();

        // unknown R-type funct is illegal too
        do_reset(6'h00, 6'h24);
        step(1'b1, 1'b0); tick();
        step(1'b0, 1'b0); tick();
        step(1'b1, 1'b0);
        check("ill_funct_flag", 32'(bus.illegal), 32'd1);
        check("ill_funct_req", 32'(bus.mem_req), 32'd0);
        tick();

        // reset during a stalled sw abandons the write
        do_reset(6'h2B, 6'h00);
        step(1'b1, 1'b0); tick();
        step(1'b0, 1'b0); tick();
        step(1'b0, 1'b0); tick();
        step(1'b0, 1'b0);
        check("swrst_mem_we", 32'(bus.mem_we), 32'd1);
        tick();
        reset_n = 1'b0;
        step(1'b1, 1'b0);
        check("swrst_req_low", 32'({bus.mem_req, bus.mem_we}), 32'd0);
        tick();
        check("swrst_retired", bus.retired, 32'd0);
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        check("swrst_fetch", 32'({bus.mem_req, bus.mem_addr_sel, bus.mem_we}), 32'b100);
        tick();

        check("pc_branch_overlap", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
